// File: rtl/dac_decimator.sv
// Third-order CIC (sinc^3) decimator: turns the 1-bit modulator stream back
// into 16-bit unsigned PCM, one sample per 2^DEC_LOG2 input bits.
module dac_decimator #(
    parameter int DEC_LOG2 = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [15:0] pcm,
    output logic        pcm_valid
);

    localparam int W = 3 * DEC_LOG2 + 1;

    // The integrators and combs wrap modulo 2^W on purpose. The comb
    // differences stay exact because the largest real output is R^3.
    logic [DEC_LOG2-1:0] cnt;
    logic [W-1:0]        i1, i2, i3;
    logic [W-1:0]        d1, d2, d3;
    logic [W-1:0]        c1, c2, y;
    logic [1:0]          warm;
    logic                tick;
    logic [15:0]         pcm_next;

    assign tick = &cnt;

    always_comb begin
        c1 = i3 - d1;
        c2 = c1 - d2;
        y  = c2 - d3;
        // y reaches 2^(W-1) only for an all-ones window.
        if (y[W-1]) pcm_next = 16'hFFFF;
        else        pcm_next = 16'(y >> (W - 17));
    end

    // pcm_valid is a one-cycle strobe, high exactly in the cycle pcm takes a
    // new value. There is no ready: the consumer must take it that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            i1        <= '0;
            i2        <= '0;
            i3        <= '0;
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            warm      <= '0;
            pcm       <= '0;
            pcm_valid <= 1'b0;
        end else begin
            cnt       <= cnt + DEC_LOG2'(1);
            i1        <= i1 + W'(din);
            i2        <= i2 + i1;
            i3        <= i3 + i2;
            pcm_valid <= 1'b0;
            if (tick) begin
                d1 <= i3;
                d2 <= c1;
                d3 <= c2;
                if (warm != 2'd3) warm <= warm + 2'd1;
                // Ticks 1 and 2 still see start-up comb delays.
                if (warm[1]) begin
                    pcm       <= pcm_next;
                    pcm_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_decimator.sv
// Directed bench for dac_decimator: one default instance (R=512) and one with
// DEC_LOG2=6 (R=64) share clock, reset and bitstream.
module tb_dac_decimator;

    localparam int R  = 512;
    localparam int RS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic [15:0] pcm, pcm_s;
    logic        pcm_valid, pcm_valid_s;

    int n_checks = 0;
    int n_errors = 0;

    dac_decimator #(.DEC_LOG2(9)) dut (
        .clk(clk), .rst(rst), .din(din), .pcm(pcm), .pcm_valid(pcm_valid)
    );

    dac_decimator #(.DEC_LOG2(6)) dut_s (
        .clk(clk), .rst(rst), .din(din), .pcm(pcm_s), .pcm_valid(pcm_valid_s)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Exact compare when tol is 0, otherwise a +/-tol window.
    task automatic check_tol(input string tag, input logic [15:0] obs, input logic [15:0] exp,
                             input int tol);
        int diff;
        diff = (obs > exp) ? int'(obs - exp) : int'(exp - obs);
        if (tol == 0) check_eq(tag, 32'(obs), 32'(exp));
        else          check_eq({tag, "_tol"}, 32'(diff <= tol), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_pcm", 32'(pcm), 32'h0);
        check_eq("rst_valid", 32'(pcm_valid), 32'h0);
        check_eq("rst_pcm_s", 32'(pcm_s), 32'h0);
        check_eq("rst_valid_s", 32'(pcm_valid_s), 32'h0);
    endtask

    // mode 0: din repeats val[0..plen-1] from cycle 0.
    // mode 1: din is the carry of a first-order accumulator fed with val.
    task automatic run(input string tag, input int mode, input logic [15:0] val, input int plen,
                       input int ncyc, input logic [15:0] exp, input int tol);
        logic [16:0] acc;
        logic [15:0] hold_b, hold_s;
        int nb, ns, cyc;
        acc    = '0;
        hold_b = '0;
        hold_s = '0;
        nb     = 0;
        ns     = 0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            rst = 1'b0;
            if (mode == 0) begin
                din = val[c % plen];
            end else begin
                acc = {1'b0, acc[15:0]} + {1'b0, val};
                din = acc[16];
            end
            @(posedge clk);
            #1;
            cyc = c + 1;
            if (pcm_valid) begin
                nb++;
                check_eq({tag, "_phase"}, 32'((cyc % R == 0) && (cyc >= 3 * R)), 32'd1);
                check_tol({tag, "_pcm"}, pcm, exp, tol);
                hold_b = exp;
            end else begin
                check_tol({tag, "_hold"}, pcm, hold_b, tol);
            end
            if (pcm_valid_s) begin
                ns++;
                check_eq({tag, "_phase_s"}, 32'((cyc % RS == 0) && (cyc >= 3 * RS)), 32'd1);
                check_tol({tag, "_pcm_s"}, pcm_s, exp, tol);
                hold_s = exp;
            end else begin
                check_tol({tag, "_hold_s"}, pcm_s, hold_s, tol);
            end
        end
        check_eq({tag, "_count"}, 32'(nb), 32'((ncyc / R >= 3) ? ncyc / R - 2 : 0));
        check_eq({tag, "_count_s"}, 32'(ns), 32'((ncyc / RS >= 3) ? ncyc / RS - 2 : 0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        run("zero", 0, 16'h0000, 1, 4 * R, 16'h0000, 0);
        run("ones", 0, 16'h0001, 1, 22 * R, 16'hFFFF, 0);
        run("alt", 0, 16'h0001, 2, 4 * R, 16'h8000, 0);
        run("p1000", 0, 16'h0001, 4, 4 * R, 16'h4000, 0);
        // Next run's reset lands at cycle 2R+100 of this one.
        run("rst_early", 0, 16'h0001, 1, 2 * R + 100, 16'hFFFF, 0);
        // Reset mid-frame while pcm holds 0xFFFF.
        run("rst_mid", 0, 16'h0001, 1, 4 * R + 100, 16'hFFFF, 0);
        // Next reset lands exactly on a tick cycle of both instances.
        run("rst_tick", 0, 16'h0001, 1, 4 * R - 1, 16'hFFFF, 0);
        run("after_rst", 0, 16'h0001, 1, 4 * R, 16'hFFFF, 0);
        run("loop_4000", 1, 16'h4000, 1, 5 * R, 16'h4000, 2);
        run("loop_c000", 1, 16'hC000, 1, 5 * R, 16'hC000, 2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
